overlay_window_ctrl: RTL and testbench

Programmable multi-window overlay generator for the VGA pixel path, the parametrised successor to the single fixed-window end-game overlay. Software programs up to NUM_WIN rectangular windows over Avalon-MM. Each window has its own position, size, image mode, ROM base address and frame-based blink. Every pixel clock the block resolves which window covers (DrawX, DrawY) and emits a registered mode, window index and image-ROM address to the color mapper. Register writes are shadowed and committed atomically at frame start, so a frame never shows a half-updated window.

---
 rtl/overlay_window_ctrl_if.sv | 19 +
 rtl/overlay_window_ctrl.sv | 177 +++++++++++++++++
 tb/tb_overlay_window_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/overlay_window_ctrl_if.sv
// rtl/overlay_window_ctrl_if.sv - Avalon-MM register bus for the overlay window controller
interface overlay_window_ctrl_if;
    logic        AVL_CS;
    logic        AVL_WRITE;
    logic        AVL_READ;
    logic [6:0]  AVL_ADDR;
    logic [31:0] AVL_WRITEDATA;
    logic [31:0] AVL_READDATA;

    modport master (
        output AVL_CS, AVL_WRITE, AVL_READ, AVL_ADDR, AVL_WRITEDATA,
        input  AVL_READDATA
    );

    modport slave (
        input  AVL_CS, AVL_WRITE, AVL_READ, AVL_ADDR, AVL_WRITEDATA,
        output AVL_READDATA
    );
endinterface

// File: rtl/overlay_window_ctrl.sv
// rtl/overlay_window_ctrl.sv - multi-window overlay generator with shadowed, frame-committed registers
module overlay_window_ctrl #(
    parameter int NUM_WIN = 4,
    parameter int ADDR_W  = 15,
    parameter int BLINK_W = 8
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [9:0]            DrawX,
    input  logic [9:0]            DrawY,
    overlay_window_ctrl_if.slave  avl,
    output logic [1:0]            ovl_on,
    output logic [3:0]            ovl_id,
    output logic [ADDR_W-1:0]     img_addr
);
    typedef struct packed {
        logic [9:0]         x;
        logic [9:0]         y;
        logic [9:0]         w;
        logic [9:0]         h;
        logic [1:0]         mode;
        logic               blink;
        logic [BLINK_W-1:0] period;
        logic [ADDR_W-1:0]  base;
    } win_t;

    win_t               sh   [NUM_WIN];
    win_t               sh_n [NUM_WIN];
    win_t               act  [NUM_WIN];
    win_t               act_n[NUM_WIN];
    logic [BLINK_W-1:0] cnt  [NUM_WIN];
    logic [BLINK_W-1:0] cnt_n[NUM_WIN];
    logic               ph   [NUM_WIN];
    logic               ph_n [NUM_WIN];
    logic               pending, pending_n, global_en, win_wr;
    logic [7:0]         frame_cnt;
    logic [31:0]        rdata_c;
    logic [1:0]         on_n;
    logic [3:0]         id_n;
    logic [ADDR_W-1:0]  addr_n;
    logic [10:0]        x11, y11, w11, h11;
    logic [9:0]         rx, ry;
    logic               hit, vis;

    logic       wr, rd, fs, commit;
    logic [3:0] aw;
    logic [2:0] fld;
    logic       unused_bits;

    assign wr          = avl.AVL_CS & avl.AVL_WRITE;
    assign rd          = avl.AVL_CS & avl.AVL_READ;
    assign aw          = avl.AVL_ADDR[6:3];
    assign fld         = avl.AVL_ADDR[2:0];
    assign fs          = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign commit      = fs && pending;
    assign unused_bits = ^avl.AVL_WRITEDATA[31:10];

    // Shadow writes, commit and blink advance; outputs below use the post-frame-start view.
    always_comb begin
        win_wr = 1'b0;
        for (int i = 0; i < NUM_WIN; i++) begin
            sh_n[i] = sh[i];
            if (wr && aw == 4'(i) && fld != 3'd7) begin
                win_wr = 1'b1;
                case (fld)
                    3'd0: sh_n[i].x      = avl.AVL_WRITEDATA[9:0];
                    3'd1: sh_n[i].y      = avl.AVL_WRITEDATA[9:0];
                    3'd2: sh_n[i].w      = avl.AVL_WRITEDATA[9:0];
                    3'd3: sh_n[i].h      = avl.AVL_WRITEDATA[9:0];
                    3'd4: {sh_n[i].blink, sh_n[i].mode} = avl.AVL_WRITEDATA[2:0];
                    3'd5: sh_n[i].period = avl.AVL_WRITEDATA[BLINK_W-1:0];
                    default: sh_n[i].base = avl.AVL_WRITEDATA[ADDR_W-1:0];
                endcase
            end
            act_n[i] = commit ? sh[i] : act[i];
            cnt_n[i] = cnt[i];
            ph_n[i]  = ph[i];
            if (commit) begin
                cnt_n[i] = '0;
                ph_n[i]  = 1'b0;
            end else if (fs && act[i].blink && act[i].period != '0) begin
                if (cnt[i] == act[i].period - BLINK_W'(1)) begin
                    cnt_n[i] = '0;
                    ph_n[i]  = ~ph[i];
                end else begin
                    cnt_n[i] = cnt[i] + BLINK_W'(1);
                end
            end
        end
        pending_n = win_wr ? 1'b1 : (commit ? 1'b0 : pending);
    end

    // Walk from the highest index down so the lowest-index hit wins.
    always_comb begin
        on_n   = 2'd0;
        id_n   = 4'd0;
        addr_n = '0;
        x11 = '0; y11 = '0; w11 = '0; h11 = '0;
        rx = '0; ry = '0; hit = 1'b0; vis = 1'b0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            x11 = {1'b0, act_n[i].x};
            y11 = {1'b0, act_n[i].y};
            w11 = {1'b0, act_n[i].w};
            h11 = {1'b0, act_n[i].h};
            rx  = DrawX - act_n[i].x;
            ry  = DrawY - act_n[i].y;
            hit = (w11 != '0) && (h11 != '0)
                && ({1'b0, DrawX} >= x11) && ({1'b0, DrawX} < x11 + w11)
                && ({1'b0, DrawY} >= y11) && ({1'b0, DrawY} < y11 + h11);
            vis = (act_n[i].mode != 2'd0)
                && (!act_n[i].blink || act_n[i].period == '0 || !ph_n[i]);
            if (hit && vis) begin
                on_n   = act_n[i].mode;
                id_n   = 4'(i);
                addr_n = ADDR_W'({22'd0, ry} * {22'd0, act_n[i].w}
                                 + {22'd0, rx} + 32'(act_n[i].base));
            end
        end
        if (!global_en) begin
            on_n   = 2'd0;
            id_n   = 4'd0;
            addr_n = '0;
        end
    end

    always_comb begin
        rdata_c = 32'd0;
        for (int i = 0; i < NUM_WIN; i++) begin
            if (aw == 4'(i)) begin
                case (fld)
                    3'd0: rdata_c = 32'(sh[i].x);
                    3'd1: rdata_c = 32'(sh[i].y);
                    3'd2: rdata_c = 32'(sh[i].w);
                    3'd3: rdata_c = 32'(sh[i].h);
                    3'd4: rdata_c = 32'({sh[i].blink, sh[i].mode});
                    3'd5: rdata_c = 32'(sh[i].period);
                    3'd6: rdata_c = 32'(sh[i].base);
                    default: rdata_c = 32'd0;
                endcase
            end
        end
        if (avl.AVL_ADDR == 7'h7E) rdata_c = {16'd0, frame_cnt, 7'd0, pending};
        if (avl.AVL_ADDR == 7'h7F) rdata_c = {31'd0, global_en};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                sh[i]  <= '0;
                act[i] <= '0;
                cnt[i] <= '0;
                ph[i]  <= 1'b0;
            end
            pending          <= 1'b0;
            global_en        <= 1'b0;
            frame_cnt        <= 8'd0;
            avl.AVL_READDATA <= 32'd0;
            ovl_on           <= 2'd0;
            ovl_id           <= 4'd0;
            img_addr         <= '0;
        end else begin
            for (int i = 0; i < NUM_WIN; i++) begin
                sh[i]  <= sh_n[i];
                act[i] <= act_n[i];
                cnt[i] <= cnt_n[i];
                ph[i]  <= ph_n[i];
            end
            pending <= pending_n;
            if (wr && avl.AVL_ADDR == 7'h7F) global_en <= avl.AVL_WRITEDATA[0];
            if (fs) frame_cnt <= frame_cnt + 8'd1;
            avl.AVL_READDATA <= rd ? rdata_c : 32'd0;
            ovl_on           <= on_n;
            ovl_id           <= id_n;
            img_addr         <= addr_n;
        end
    end
endmodule

// File: tb/tb_overlay_window_ctrl.sv
// tb/tb_overlay_window_ctrl.sv - directed self-checking bench for overlay_window_ctrl
module tb_overlay_window_ctrl;
    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [9:0]  DrawX = 10'd1023;
    logic [9:0]  DrawY = 10'd1023;
    logic [1:0]  ovl_on;
    logic [3:0]  ovl_id;
    logic [14:0] img_addr;
    int          tests = 0;
    int          fails = 0;
    int          fc = 0;

    overlay_window_ctrl_if avl ();

    overlay_window_ctrl #(.NUM_WIN(4), .ADDR_W(15), .BLINK_W(8)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DrawX(DrawX), .DrawY(DrawY),
        .avl(avl), .ovl_on(ovl_on), .ovl_id(ovl_id), .img_addr(img_addr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        avl.AVL_CS = 1'b1; avl.AVL_WRITE = 1'b1; avl.AVL_ADDR = a; avl.AVL_WRITEDATA = d;
        step();
        avl.AVL_CS = 1'b0; avl.AVL_WRITE = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [6:0] a, input logic [31:0] exp);
        avl.AVL_CS = 1'b1; avl.AVL_READ = 1'b1; avl.AVL_ADDR = a;
        step();
        avl.AVL_CS = 1'b0; avl.AVL_READ = 1'b0;
        check(tag, avl.AVL_READDATA, exp);
    endtask

    // Drives one pixel for one cycle, then parks the scan off-screen.
    task automatic pix(input int x, input int y);
        DrawX = 10'(x); DrawY = 10'(y);
        step();
        if (x == 0 && y == 0) fc = (fc + 1) % 256;
        DrawX = 10'd1023; DrawY = 10'd1023;
    endtask

    task automatic pix_chk(input string tag, input int x, input int y,
                           input int on, input int id, input int addr);
        pix(x, y);
        check({tag, ".on"}, 32'(ovl_on), 32'(on));
        check({tag, ".id"}, 32'(ovl_id), 32'(id));
        check({tag, ".addr"}, 32'(img_addr), 32'(addr));
    endtask

    task automatic win(input int w, input int x, input int y, input int ww, input int hh,
                       input int ctrl, input int period, input int base);
        wr(7'(8*w + 0), 32'(x));
        wr(7'(8*w + 1), 32'(y));
        wr(7'(8*w + 2), 32'(ww));
        wr(7'(8*w + 3), 32'(hh));
        wr(7'(8*w + 4), 32'(ctrl));
        wr(7'(8*w + 5), 32'(period));
        wr(7'(8*w + 6), 32'(base));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        avl.AVL_CS = 1'b0; avl.AVL_WRITE = 1'b0; avl.AVL_READ = 1'b0;
        avl.AVL_ADDR = 7'd0; avl.AVL_WRITEDATA = 32'd0;
        repeat (3) step();
        check("rst.on", 32'(ovl_on), 0);
        check("rst.id", 32'(ovl_id), 0);
        check("rst.addr", 32'(img_addr), 0);
        check("rst.rdata", avl.AVL_READDATA, 0);
        RESET_N = 1'b1;
        step();

        wr(7'h7F, 32'd1);
        pix(0, 0);
        pix_chk("gen_only", 130, 190, 0, 0, 0);

        win(0, 120, 180, 240, 120, 1, 0, 0);
        rd_chk("status.pend", 7'h7E, {16'd0, 8'(fc), 8'd1});
        pix_chk("precommit", 120, 180, 0, 0, 0);
        pix(0, 0);
        rd_chk("status.clr", 7'h7E, {16'd0, 8'(fc), 8'd0});
        pix_chk("w0.corner", 120, 180, 1, 0, 0);
        pix_chk("w0.far", 359, 299, 1, 0, 28799);
        pix_chk("w0.right", 360, 299, 0, 0, 0);
        pix_chk("w0.left", 119, 180, 0, 0, 0);
        pix_chk("w0.below", 359, 300, 0, 0, 0);

        wr(7'd0, 32'd200);
        pix_chk("shadow.old", 150, 200, 1, 0, 4830);
        rd_chk("shadow.pend", 7'h7E, {16'd0, 8'(fc), 8'd1});
        pix(0, 0);
        rd_chk("shadow.clr", 7'h7E, {16'd0, 8'(fc), 8'd0});
        pix_chk("shadow.new_out", 150, 200, 0, 0, 0);
        pix_chk("shadow.new_in", 200, 180, 1, 0, 0);

        wr(7'd0, 32'd120);
        wr(7'd4, 32'd2);
        win(1, 300, 250, 100, 100, 3, 0, 100);
        pix(0, 0);
        pix_chk("prio.w0", 320, 260, 2, 0, 19400);
        pix_chk("prio.w1", 380, 260, 3, 1, 1180);
        wr(7'd4, 32'd0);
        pix(0, 0);
        pix_chk("transp", 320, 260, 3, 1, 1120);

        wr(7'd12, 32'd0);
        wr(7'd4, 32'd5);
        wr(7'd5, 32'd3);
        pix(0, 0);
        for (int f = 0; f < 7; f++) begin
            pix(130, 190);
            check($sformatf("blink.f%0d", f), 32'(ovl_on), ((f / 3) % 2 == 0) ? 1 : 0);
            pix(0, 0);
        end
        wr(7'd5, 32'd0);
        pix(0, 0);
        for (int f = 0; f < 4; f++) begin
            pix(130, 190);
            check($sformatf("period0.f%0d", f), 32'(ovl_on), 1);
            pix(0, 0);
        end

        win(2, 10, 10, 32, 8, 1, 0, 32'h7FF0);
        win(3, 500, 10, 0, 10, 1, 0, 0);
        pix(0, 0);
        pix_chk("wrap", 11, 11, 1, 2, 32'h11);
        pix_chk("w_zero", 500, 10, 0, 0, 0);
        rd_chk("readback", 7'd16, 32'd10);
        rd_chk("readback.base", 7'd22, 32'h7FF0);
        wr(7'h07, 32'h55);
        rd_chk("ign.read", 7'h07, 0);
        rd_chk("ign.pend", 7'h7E, {16'd0, 8'(fc), 8'd0});
        wr(7'h7F, 32'd0);
        rd_chk("gctrl.read", 7'h7F, 0);
        pix_chk("gdis", 11, 11, 0, 0, 0);

        wr(7'h7F, 32'd1);
        DrawX = 10'd11; DrawY = 10'd11;
        step();
        check("pre_rst.on", 32'(ovl_on), 1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("async.on", 32'(ovl_on), 0);
        check("async.addr", 32'(img_addr), 0);
        step();
        check("async.rdata", avl.AVL_READDATA, 0);
        RESET_N = 1'b1;
        DrawX = 10'd1023; DrawY = 10'd1023;
        step();
        rd_chk("post_rst.status", 7'h7E, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
